vga_scaled_framebuffer: RTL



---
 rtl/vga_scaled_framebuffer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_scaled_framebuffer.sv
// vga_scaled_framebuffer: 640x480 VGA timing, scaled framebuffer, DAC pipeline.
// Define DOUBLE_BUFFER_EN for two banks with a vblank-synchronous swap.
module vga_scaled_framebuffer #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SCALE_LOG2 = 2,
  parameter int CB         = 3
) (
  input  logic          Fast_Clock,
  input  logic          Reset_N,
  input  logic          Draw_Valid,
  output logic          Draw_Ready,
  input  logic [15:0]   Draw_X,
  input  logic [15:0]   Draw_Y,
  input  logic [3*CB-1:0] Draw_Color,
  output logic          Draw_Drop,
  input  logic          Clear_Start,
  input  logic [3*CB-1:0] Clear_Color,
  output logic          Clear_Busy,
  input  logic          Swap_Request,
  output logic          Swap_Pending,
  output logic          Frame_Start,
  output logic          VGA_Clk,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic [7:0]    VGA_Red,
  output logic [7:0]    VGA_Green,
  output logic [7:0]    VGA_Blue,
  output logic          VGA_Blank_N,
  output logic          VGA_Sync_N
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_WIDTH  = H_ACTIVE >> SCALE_LOG2;
  localparam int FB_HEIGHT = V_ACTIVE >> SCALE_LOG2;
  localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;
`ifdef DOUBLE_BUFFER_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  localparam int MEM_WORDS = BANKS * FB_WORDS;
  localparam int AW = $clog2(MEM_WORDS);
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);
  localparam int CW = $clog2(FB_WORDS);
  localparam int W  = 3 * CB;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   clr_cnt;
  logic [W-1:0]    clr_color;
  logic [W-1:0]    mem [MEM_WORDS];
  logic [W-1:0]    rd_data;
  logic [W-1:0]    wr_data;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   wr_addr;
  logic [31:0]     rd_lin;
  logic [31:0]     draw_lin;
  logic [31:0]     wr_lin;
  logic [31:0]     rd_base;
  logic [31:0]     wr_base;
  logic            active;
  logic            hs_n;
  logic            vs_n;
  logic            hs_d1;
  logic            vs_d1;
  logic            act_d1;
  logic            in_range;
  logic            draw_fire;
  logic            we;
  logic            vblank_start;
  logic            front;
  logic            pending;

  function automatic logic [7:0] expand(input logic [CB-1:0] c);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r[7-i] = c[CB-1-(i%CB)];
    return r;
  endfunction

  assign VGA_Clk    = ~Fast_Clock;
  assign VGA_Sync_N = 1'b0;

  assign active = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
  assign hs_n   = !((x >= XW'(H_ACTIVE + H_FP)) &&
                    (x <  XW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_n   = !((y >= YW'(V_ACTIVE + V_FP)) &&
                    (y <  YW'(V_ACTIVE + V_FP + V_SYNC)));
  assign vblank_start = (x == '0) && (y == YW'(V_ACTIVE));

  // Scan counters; Frame_Start is raised as the counters wrap to 0,0
  always_ff @(posedge Fast_Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      x           <= '0;
      y           <= '0;
      Frame_Start <= 1'b0;
    end else begin
      Frame_Start <= (x == XW'(H_TOTAL - 1)) && (y == YW'(V_TOTAL - 1));
      if (x == XW'(H_TOTAL - 1)) begin
        x <= '0;
        y <= (y == YW'(V_TOTAL - 1)) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

`ifdef DOUBLE_BUFFER_EN
  // Bank swap at the first vblank cycle, held off while a clear runs
  always_ff @(posedge Fast_Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      front   <= 1'b0;
      pending <= 1'b0;
    end else if (vblank_start && (pending || Swap_Request) && !Clear_Busy) begin
      front   <= ~front;
      pending <= 1'b0;
    end else if (Swap_Request) begin
      pending <= 1'b1;
    end
  end
  assign rd_base = front ? 32'(FB_WORDS) : 32'd0;
  assign wr_base = front ? 32'd0 : 32'(FB_WORDS);
`else
  logic unused_swap;
  assign unused_swap = Swap_Request ^ vblank_start;
  assign front   = 1'b0;
  assign pending = 1'b0;
  assign rd_base = 32'd0;
  assign wr_base = 32'd0;
`endif
  assign Swap_Pending = pending;

  assign rd_lin   = 32'(y >> SCALE_LOG2) * 32'(FB_WIDTH) + 32'(x >> SCALE_LOG2);
  assign rd_addr  = active ? AW'(rd_lin + rd_base) : '0;
  assign in_range = (32'(Draw_X) < 32'(FB_WIDTH)) &&
                    (32'(Draw_Y) < 32'(FB_HEIGHT));
  assign draw_lin = 32'(Draw_Y) * 32'(FB_WIDTH) + 32'(Draw_X);
  assign draw_fire = (state == IDLE) && !Clear_Start && Draw_Valid && Draw_Ready;
  assign we       = (state == CLEAR) || (draw_fire && in_range);
  assign wr_lin   = (state == CLEAR) ? 32'(clr_cnt) : draw_lin;
  assign wr_data  = (state == CLEAR) ? clr_color : Draw_Color;
  assign wr_addr  = AW'(wr_lin + wr_base);

  // Framebuffer RAM: one write port, registered display read
  always_ff @(posedge Fast_Clock) begin
    if (we)
      mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  // Write FSM: draw port in IDLE, one fill word per cycle in CLEAR
  always_ff @(posedge Fast_Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state      <= IDLE;
      Draw_Ready <= 1'b0;
      Draw_Drop  <= 1'b0;
      Clear_Busy <= 1'b0;
      clr_cnt    <= '0;
      clr_color  <= '0;
    end else begin
      Draw_Drop <= 1'b0;
      unique case (state)
        IDLE: begin
          Draw_Ready <= 1'b1;
          if (Clear_Start) begin
            state      <= CLEAR;
            Clear_Busy <= 1'b1;
            Draw_Ready <= 1'b0;
            clr_cnt    <= '0;
            clr_color  <= Clear_Color;
          end else if (draw_fire) begin
            Draw_Drop <= !in_range;
          end
        end
        CLEAR: begin
          if (clr_cnt == CW'(FB_WORDS - 1)) begin
            state      <= IDLE;
            Clear_Busy <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: syncs delayed twice to line up with the RAM read
  always_ff @(posedge Fast_Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      act_d1      <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_Blank_N <= 1'b0;
      VGA_Red     <= 8'h00;
      VGA_Green   <= 8'h00;
      VGA_Blue    <= 8'h00;
    end else begin
      hs_d1       <= hs_n;
      vs_d1       <= vs_n;
      act_d1      <= active;
      VGA_HS      <= hs_d1;
      VGA_VS      <= vs_d1;
      VGA_Blank_N <= act_d1;
      VGA_Red     <= act_d1 ? expand(rd_data[3*CB-1:2*CB]) : 8'h00;
      VGA_Green   <= act_d1 ? expand(rd_data[2*CB-1:CB]) : 8'h00;
      VGA_Blue    <= act_d1 ? expand(rd_data[CB-1:0]) : 8'h00;
    end
  end

endmodule
